// File: rtl/dskw_frame_ctrl.sv
// Port-A BRAM master and Deskew initiator: loads one frame into BRAM, runs Deskew,
// then streams the deskewed frame out with a last flag.
module dskw_frame_ctrl #(
   parameter int WIDTH    = 16,
   parameter int PIXELS   = 784,
   parameter int ADDR_W   = 11,
   parameter int IN_BASE  = 0,
   parameter int OUT_BASE = 784
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [WIDTH-1:0]  m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              frame_done,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [WIDTH-1:0]  bram_din,
   input  logic [WIDTH-1:0]  bram_dout,
   output logic              bram_en,
   output logic              bram_we,
   output logic              dskw_start,
   input  logic              dskw_ready
);

   localparam int CNT_W = $clog2(PIXELS);
   localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(PIXELS - 1);
   localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
   localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);

   generate
      if ((IN_BASE + PIXELS > (1 << ADDR_W)) || (OUT_BASE + PIXELS > (1 << ADDR_W))) begin : g_addr_range_err
         $error("dskw_frame_ctrl: image region exceeds BRAM address space");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_RD_REQ, S_RD_CAP, S_RD_OUT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               s_ready_q, s_ready_d;
   logic [WIDTH-1:0]   m_data_q, m_data_d;
   logic               m_valid_q, m_valid_d;
   logic               m_last_q, m_last_d;
   logic               frame_done_q, frame_done_d;
   logic [ADDR_W-1:0]  bram_addr_q, bram_addr_d;
   logic [WIDTH-1:0]   bram_din_q, bram_din_d;
   logic               bram_en_q, bram_en_d;
   logic               bram_we_q, bram_we_d;
   logic               dskw_start_q, dskw_start_d;
   logic               s_fire;
   logic [CNT_W-1:0]   cnt_inc;

   assign s_fire  = s_valid && s_ready_q;
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      s_ready_d    = 1'b0;
      m_data_d     = m_data_q;
      m_valid_d    = m_valid_q;
      m_last_d     = m_last_q;
      frame_done_d = 1'b0;
      bram_addr_d  = bram_addr_q;
      bram_din_d   = bram_din_q;
      bram_en_d    = 1'b0;
      bram_we_d    = 1'b0;
      dskw_start_d = 1'b0;

      case (state_q)
         S_IDLE, S_LOAD: begin
            s_ready_d = (state_q == S_LOAD) ? 1'b1 : dskw_ready;
            if (s_fire) begin
               bram_en_d   = 1'b1;
               bram_we_d   = 1'b1;
               bram_addr_d = IN_BASE_A + ADDR_W'(cnt_q);
               bram_din_d  = s_data;
               if (cnt_q == LAST_CNT) begin
                  cnt_d     = '0;
                  s_ready_d = 1'b0;
                  state_d   = S_START;
               end else begin
                  cnt_d     = cnt_inc;
                  s_ready_d = 1'b1;
                  state_d   = S_LOAD;
               end
            end
         end
         S_START: begin
            dskw_start_d = 1'b1;
            state_d      = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!dskw_ready) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // Read request is registered on the way into RD_REQ so BRAM sees it during RD_REQ.
            if (dskw_ready) begin
               bram_en_d   = 1'b1;
               bram_addr_d = OUT_BASE_A + ADDR_W'(cnt_q);
               state_d     = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            state_d = S_RD_CAP;
         end
         S_RD_CAP: begin
            m_data_d  = bram_dout;
            m_valid_d = 1'b1;
            m_last_d  = (cnt_q == LAST_CNT);
            state_d   = S_RD_OUT;
         end
         S_RD_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if (cnt_q == LAST_CNT) begin
                  frame_done_d = 1'b1;
                  cnt_d        = '0;
                  state_d      = S_IDLE;
               end else begin
                  cnt_d       = cnt_inc;
                  bram_en_d   = 1'b1;
                  bram_addr_d = OUT_BASE_A + ADDR_W'(cnt_inc);
                  state_d     = S_RD_REQ;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         s_ready_q    <= 1'b0;
         m_data_q     <= '0;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         frame_done_q <= 1'b0;
         bram_addr_q  <= '0;
         bram_din_q   <= '0;
         bram_en_q    <= 1'b0;
         bram_we_q    <= 1'b0;
         dskw_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         s_ready_q    <= s_ready_d;
         m_data_q     <= m_data_d;
         m_valid_q    <= m_valid_d;
         m_last_q     <= m_last_d;
         frame_done_q <= frame_done_d;
         bram_addr_q  <= bram_addr_d;
         bram_din_q   <= bram_din_d;
         bram_en_q    <= bram_en_d;
         bram_we_q    <= bram_we_d;
         dskw_start_q <= dskw_start_d;
      end
   end

   assign s_ready    = s_ready_q;
   assign m_data     = m_data_q;
   assign m_valid    = m_valid_q;
   assign m_last     = m_last_q;
   assign busy       = (state_q != S_IDLE);
   assign frame_done = frame_done_q;
   assign bram_addr  = bram_addr_q;
   assign bram_din   = bram_din_q;
   assign bram_en    = bram_en_q;
   assign bram_we    = bram_we_q;
   assign dskw_start = dskw_start_q;

endmodule

// File: tb/tb_dskw_frame_ctrl.sv
// Scoreboarded bench for dskw_frame_ctrl with a BRAM + Deskew (out = in + 1) model.
module tb_dskw_frame_ctrl;
   localparam int W  = 16;
   localparam int P  = 784;
   localparam int AW = 11;
   localparam int OB = 784;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [W-1:0]  s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [W-1:0]  m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic          busy;
   logic          frame_done;
   logic [AW-1:0] bram_addr;
   logic [W-1:0]  bram_din;
   logic [W-1:0]  bram_dout;
   logic          bram_en;
   logic          bram_we;
   logic          dskw_start;
   logic          dskw_ready;

   dskw_frame_ctrl dut (
      .clk(clk), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .busy(busy), .frame_done(frame_done),
      .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
      .bram_en(bram_en), .bram_we(bram_we),
      .dskw_start(dskw_start), .dskw_ready(dskw_ready)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int start_cnt = 0;
   int rdy_mode = 0;
   int hold_cycles = 1;
   int busy_cycles = 5;

   logic [W-1:0]    src [P];
   logic [W-1:0]    mem [0:2047];
   logic [W:0]      exp_q [$];
   logic [AW+W-1:0] wq [$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // BRAM port A plus a Deskew engine that owns port B while busy.
   int dsk_phase = 0;
   int dsk_cnt = 0;
   always @(posedge clk) begin
      if (reset) begin
         dsk_phase  <= 0;
         dskw_ready <= 1'b1;
      end else begin
         if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_dout <= mem[bram_addr];
         end
         case (dsk_phase)
            0: if (dskw_start) begin
                  dsk_phase <= 1;
                  dsk_cnt   <= hold_cycles;
               end
            1: if (dsk_cnt <= 1) begin
                  dskw_ready <= 1'b0;
                  dsk_phase  <= 2;
                  dsk_cnt    <= busy_cycles;
               end else dsk_cnt <= dsk_cnt - 1;
            default: if (dsk_cnt <= 1) begin
                  for (int k = 0; k < P; k++) mem[OB+k] <= mem[k] + 16'd1;
                  dskw_ready <= 1'b1;
                  dsk_phase  <= 0;
               end else dsk_cnt <= dsk_cnt - 1;
         endcase
      end
   end

   initial begin
      int cyc;
      cyc = 0;
      m_ready = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 3) == 0);
            default: m_ready = (($urandom & 1) != 0);
         endcase
      end
   end

   // Monitor: pops the scoreboards whenever the DUT presents a write or an output.
   initial begin
      logic            prev_stall;
      logic [W:0]      prev_out;
      logic [W:0]      e;
      logic [AW+W-1:0] w;
      prev_stall = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) check("m_hold", {15'd0, m_valid, m_last, m_data}, {15'd0, 1'b1, prev_out});
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) check("unexpected_output", 32'd1, 32'd0);
               else begin
                  e = exp_q.pop_front();
                  check("m_out", {15'd0, m_last, m_data}, {15'd0, e});
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_last, m_data};
            if (bram_en && bram_we) begin
               if (wq.size() == 0) check("unexpected_write", 32'd1, 32'd0);
               else begin
                  w = wq.pop_front();
                  check("bram_write", {5'd0, bram_addr, bram_din}, {5'd0, w});
               end
            end
            if (bram_en && !bram_we) check("read_while_deskew_busy", 32'(dsk_phase != 0), 32'd0);
            if (dskw_start) start_cnt++;
            if (frame_done) begin
               done_cnt++;
               check("idle_at_frame_done", {31'd0, busy}, 32'd0);
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rst_ctrl"}, {24'd0, s_ready, m_valid, m_last, busy, frame_done, bram_en, bram_we, dskw_start}, 32'd0);
      check({tag, "_rst_data"}, {m_data, bram_din}, 32'd0);
      check({tag, "_rst_addr"}, {21'd0, bram_addr}, 32'd0);
   endtask

   task automatic fill_random();
      for (int k = 0; k < P; k++) src[k] = W'($urandom);
   endtask

   task automatic feed(input int gap_max, input int abort_at, input int gate_base, output bit aborted);
      int i;
      int gap;
      int guard;
      i = 0; gap = 0; guard = 0; aborted = 1'b0;
      while (i < P && !aborted && guard < 60000) begin
         @(negedge clk);
         guard++;
         if (i == abort_at) begin
            reset   = 1'b1;
            s_valid = 1'b0;
            #1;
            check_reset_outputs("abort");
            repeat (2) @(negedge clk);
            wq.delete();
            reset   = 1'b0;
            aborted = 1'b1;
         end else if (gap > 0) begin
            s_valid = 1'b0;
            gap--;
         end else begin
            s_valid = 1'b1;
            s_data  = src[i];
            if (s_ready) begin
               if (i == 0 && gate_base >= 0) check("load_gated_by_done", 32'(done_cnt), 32'(gate_base + 1));
               wq.push_back({AW'(i), src[i]});
               i++;
               if (gap_max > 0) gap = int'($urandom_range(gap_max, 0));
            end
         end
      end
      if (guard >= 60000) check("feed_timeout", 32'(i), 32'(P));
      if (!aborted && i == P)
         for (int k = 0; k < P; k++) exp_q.push_back({(k == P - 1), W'(src[k] + 16'd1)});
   endtask

   task automatic wait_done(input int target);
      int c;
      c = 0;
      while (done_cnt < target && c < 40000) begin
         @(negedge clk);
         c++;
      end
      if (done_cnt < target) check("frame_done_timeout", 32'(done_cnt), 32'(target));
   endtask

   task automatic post_checks(input string name, input int done_exp, input int start_exp);
      int mism;
      repeat (3) @(negedge clk);
      mism = 0;
      for (int k = 0; k < P; k++) if (mem[k] !== src[k]) mism++;
      check("frame_done_pulses", 32'(done_cnt), 32'(done_exp));
      check("dskw_start_pulses", 32'(start_cnt), 32'(start_exp));
      check("bram_input_image", 32'(mism), 32'd0);
      check("outputs_drained", 32'(exp_q.size()), 32'd0);
      check("writes_drained", 32'(wq.size()), 32'd0);
      $display("[TB] %s: frames=%0d starts=%0d tests=%0d", name, done_cnt, start_cnt, tests);
   endtask

   task automatic run_frame(input int gap_max, input string name);
      int base;
      int sbase;
      bit ab;
      base  = done_cnt;
      sbase = start_cnt;
      feed(gap_max, -1, -1, ab);
      @(negedge clk);
      s_valid = 1'b0;
      wait_done(base + 1);
      post_checks(name, base + 1, sbase + 1);
   endtask

   initial begin
      int base;
      int sbase;
      bit ab;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("init");
      @(negedge clk);
      reset = 1'b0;

      hold_cycles = 1; busy_cycles = 5; rdy_mode = 0;
      for (int k = 0; k < P; k++) src[k] = W'(k);
      run_frame(0, "T1 ramp");

      rdy_mode = 1; busy_cycles = int'($urandom_range(30, 3));
      fill_random();
      run_frame(0, "T2 m_ready 1-of-3");

      rdy_mode = 2;
      fill_random();
      run_frame(5, "T3 s_valid gaps");

      rdy_mode = 0;
      fill_random();
      feed(0, 400, -1, ab);
      check("abort_taken", {31'd0, ab}, 32'd1);
      fill_random();
      run_frame(0, "T4 after reset");

      base = done_cnt; sbase = start_cnt;
      fill_random();
      feed(0, -1, -1, ab);
      fill_random();
      feed(0, -1, base, ab);
      @(negedge clk);
      s_valid = 1'b0;
      wait_done(base + 2);
      post_checks("T5 back-to-back", base + 2, sbase + 2);

      hold_cycles = 10; rdy_mode = 2;
      fill_random();
      run_frame(0, "T6 late ready drop");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
